// File: rtl/frame_capture_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : frame_capture_sequencer_pkg
// Purpose : Shared state encoding and default geometry for the frame capture
//           sequencer.
// Rev     : 1.0
// ============================================================================
package frame_capture_sequencer_pkg;

  localparam int c_frame_pixels_dflt = 76800;  // 320x240
  localparam int c_addr_w_dflt       = 17;
  localparam int c_data_w_dflt       = 12;     // RGB444

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_wait_vs = 2'd1;
  localparam logic [1:0] c_st_capture = 2'd2;
  localparam logic [1:0] c_st_done    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = c_st_idle,
    ST_WAIT_VS = c_st_wait_vs,
    ST_CAPTURE = c_st_capture,
    ST_DONE    = c_st_done
  } state_t;

endpackage
`default_nettype wire

// File: rtl/frame_capture_sequencer_vsync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module  : vsync_edge_detect
// Purpose : Rise/fall pulses of vsync_in against its registered history.
// Rev     : 1.0
// ============================================================================
module vsync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic vsync_in,
  output logic rise,
  output logic fall
);

  logic r_prev;
  logic r_primed;

  // First cycle after reset only loads the history, so no edge is invented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev   <= 1'b0;
      r_primed <= 1'b0;
    end else begin
      r_prev   <= vsync_in;
      r_primed <= 1'b1;
    end
  end

  assign rise = r_primed &  vsync_in & ~r_prev;
  assign fall = r_primed & ~vsync_in &  r_prev;

endmodule
`default_nettype wire

// File: rtl/frame_capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : frame_capture_sequencer
// Purpose : Captures camera frames into a buffer RAM between vsync edges.
// Rev     : 1.0
// ============================================================================
module frame_capture_sequencer
  import frame_capture_sequencer_pkg::*;
#(
  parameter int FRAME_PIXELS = c_frame_pixels_dflt,
  parameter int ADDR_W       = c_addr_w_dflt,
  parameter int DATA_W       = c_data_w_dflt
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_capture,
  input  logic              continuous,
  input  logic              vsync_in,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        frame_count,
  output logic              short_frame,
  output logic              overflow,
  output logic [1:0]        state_out
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] c_frame_pixels = CW'(FRAME_PIXELS);

  state_t            r_state;
  state_t            w_state_next;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_exit;
  logic              r_wea;
  logic [ADDR_W-1:0] r_addra;
  logic [DATA_W-1:0] r_dina;
  logic [7:0]        r_frame_count;
  logic              r_short;
  logic              r_overflow;
  logic              w_vs_rise;
  logic              w_vs_fall;
  logic              w_start_ok;
  logic              w_pix_write;
  logic              w_pix_drop;
  logic              w_capture_end;

  vsync_edge_detect u_vsync_edge (
    .clk      (clk),
    .reset    (reset),
    .vsync_in (vsync_in),
    .rise     (w_vs_rise),
    .fall     (w_vs_fall)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start_ok   = 1'b0;
    w_pix_write  = 1'b0;
    w_pix_drop   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_capture) begin
          w_start_ok   = 1'b1;
          w_state_next = ST_WAIT_VS;
        end
      end
      ST_WAIT_VS: begin
        if (w_vs_fall) w_state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (pix_valid) begin
          if (r_count < c_frame_pixels) w_pix_write = 1'b1;
          else                          w_pix_drop  = 1'b1;
        end
        if (w_vs_rise) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_state_next = continuous ? ST_WAIT_VS : ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Pixel accepted in the exit cycle still counts toward the frame length.
  assign w_count_exit  = r_count + CW'(w_pix_write);
  assign w_capture_end = (r_state == ST_CAPTURE) && w_vs_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count       <= '0;
      r_wea         <= 1'b0;
      r_addra       <= '0;
      r_dina        <= '0;
      r_frame_count <= '0;
      r_short       <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_wea <= w_pix_write;
      if (w_pix_write) begin
        r_addra <= r_count[ADDR_W-1:0];
        r_dina  <= pix_data;
      end
      if (r_state != ST_CAPTURE) r_count <= '0;
      else                       r_count <= w_count_exit;
      if (w_start_ok) begin
        r_short    <= 1'b0;
        r_overflow <= 1'b0;
      end else begin
        if (w_pix_drop) r_overflow <= 1'b1;
        if (w_capture_end && (w_count_exit < c_frame_pixels)) r_short <= 1'b1;
      end
      if (w_capture_end) r_frame_count <= r_frame_count + 8'd1;
    end
  end

  assign wea         = r_wea;
  assign addra       = r_addra;
  assign dina        = r_dina;
  assign busy        = (r_state != ST_IDLE);
  assign frame_done  = (r_state == ST_DONE);
  assign frame_count = r_frame_count;
  assign short_frame = r_short;
  assign overflow    = r_overflow;
  assign state_out   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_frame_capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_frame_capture_sequencer
// Purpose : Randomized scoreboard bench for frame_capture_sequencer.
// Rev     : 1.0
// ============================================================================
module tb_frame_capture_sequencer;

  localparam int FP = 200;
  localparam int AW = 8;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start_capture = 1'b0;
  logic          continuous = 1'b0;
  logic          vsync_in = 1'b1;
  logic          pix_valid = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic          wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic          busy;
  logic          frame_done;
  logic [7:0]    frame_count;
  logic          short_frame;
  logic          overflow;
  logic [1:0]    state_out;

  frame_capture_sequencer #(.FRAME_PIXELS(FP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start_capture(start_capture), .continuous(continuous),
    .vsync_in(vsync_in), .pix_valid(pix_valid), .pix_data(pix_data),
    .wea(wea), .addra(addra), .dina(dina), .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count), .short_frame(short_frame), .overflow(overflow),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   fc_exp = 0;
  int   done_exp = 0;
  bit   short_exp = 0;
  bit   ovf_exp = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the oldest outstanding pixel, one cycle after issue.
  always @(negedge clk) begin
    if (reset) begin
      chk("wea_in_reset", {31'd0, wea}, 32'd0);
    end else begin
      if (wea) begin
        if (q.size() == 0) begin
          chk("unexpected_write", {31'd0, wea}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("wr_addr", {24'd0, addra}, {24'd0, e.addr});
          chk("wr_data", {20'd0, dina}, {20'd0, e.data});
          chk("wr_latency", cyc, e.cyc);
        end
      end
      if (frame_done) done_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start_capture = 1'b1;
    short_exp = 0;
    ovf_exp = 0;
    step();
    start_capture = 1'b0;
  endtask

  // Precondition: DUT waiting for vsync fall with vsync_in high.
  task automatic run_frame(input int n, input bit coincident, input bit poke_start);
    repeat (3) begin
      pix_valid = 1'b1;
      pix_data  = DW'($urandom);
      step();
    end
    pix_valid = 1'b0;
    vsync_in  = 1'b0;
    step();
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b0;
      repeat ($urandom_range(0, 2)) step();
      pix_valid = 1'b1;
      pix_data  = DW'($urandom);
      if (i < FP) q.push_back('{addr: AW'(i), data: pix_data, cyc: cyc + 1});
      if (coincident && i == n - 1) vsync_in = 1'b1;
      if (poke_start && i == n / 2) start_capture = 1'b1;
      step();
      start_capture = 1'b0;
    end
    pix_valid = 1'b0;
    if (!coincident) begin
      vsync_in = 1'b1;
      step();
    end
    repeat (3) begin
      pix_valid = 1'b1;
      pix_data  = DW'($urandom);
      step();
    end
    pix_valid = 1'b0;
    repeat (2) step();
    fc_exp   = (fc_exp + 1) % 256;
    done_exp = done_exp + 1;
    if (n < FP) short_exp = 1;
    if (n > FP) ovf_exp = 1;
  endtask

  task automatic frame_checks(input logic [1:0] st_exp);
    chk("frame_count", {24'd0, frame_count}, fc_exp);
    chk("short_frame", {31'd0, short_frame}, {31'd0, short_exp});
    chk("overflow", {31'd0, overflow}, {31'd0, ovf_exp});
    chk("state_out", {30'd0, state_out}, {30'd0, st_exp});
    chk("busy", {31'd0, busy}, {31'd0, (st_exp != 2'd0)});
    chk("frame_done_pulses", done_cnt, done_exp);
    chk("pending_writes", q.size(), 0);
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) step();
    chk("rst_wea", {31'd0, wea}, 32'd0);
    chk("rst_addra", {24'd0, addra}, 32'd0);
    chk("rst_dina", {20'd0, dina}, 32'd0);
    chk("rst_state", {30'd0, state_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_frame_count", {24'd0, frame_count}, 32'd0);
    chk("rst_short", {31'd0, short_frame}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    repeat (2) step();

    // Full single-shot frame.
    do_start();
    run_frame(FP, 1'b0, 1'b0);
    frame_checks(2'd0);

    // Short frame.
    do_start();
    run_frame(100, 1'b0, 1'b0);
    frame_checks(2'd0);

    // Overflowing frame; a start pulse during capture must be ignored.
    do_start();
    run_frame(FP + 2, 1'b0, 1'b1);
    frame_checks(2'd0);

    // Continuous mode, three frames of random length.
    continuous = 1'b1;
    do_start();
    for (int f = 0; f < 3; f++) begin
      if (f == 2) continuous = 1'b0;
      run_frame($urandom_range(FP - 5, FP + 3), 1'b0, 1'b0);
      frame_checks((f == 2) ? 2'd0 : 2'd1);
    end

    // Last pixel coincides with the vsync rise.
    do_start();
    run_frame(FP, 1'b1, 1'b1);
    frame_checks(2'd0);

    // Reset in the middle of a frame while a write is on the port.
    do_start();
    vsync_in = 1'b0;
    step();
    for (int i = 0; i < 51; i++) begin
      pix_valid = 1'b1;
      pix_data  = DW'($urandom);
      q.push_back('{addr: AW'(i), data: pix_data, cyc: cyc + 1});
      if (i < 50) step();
    end
    @(posedge clk);
    #2 reset = 1'b1;
    q.delete();
    #1;
    chk("abort_wea", {31'd0, wea}, 32'd0);
    chk("abort_state", {30'd0, state_out}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_frame_count", {24'd0, frame_count}, 32'd0);
    repeat (3) begin
      vsync_in = ~vsync_in;
      step();
    end
    reset     = 1'b0;
    pix_valid = 1'b0;
    vsync_in  = 1'b1;
    fc_exp    = 0;
    short_exp = 0;
    ovf_exp   = 0;
    repeat (3) step();
    chk("abort_no_done", done_cnt, done_exp);
    do_start();
    repeat (3) step();
    chk("no_spurious_edge", {30'd0, state_out}, 32'd1);
    run_frame(FP, 1'b0, 1'b0);
    frame_checks(2'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
